// File: rtl/mul_share_pkg.sv
// Shared types and default sizing for the multiplier-sharing controller.
package mul_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WIDTH_DEF  = 16;
  localparam int SETTLE_DEF = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the requester not granted last wins a tie.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o[0] = valid_i[0] & (last_grant_i | ~valid_i[1]);
    grant_o[1] = valid_i[1] & (~last_grant_i | ~valid_i[0]);
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Time-shares one external combinational multiplier between two requesters:
// arbitrate, launch operands, wait SETTLE cycles, capture and return the product.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [2*WIDTH-1:0] rsp0_prod,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [2*WIDTH-1:0] rsp1_prod,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_prod,
  output logic               busy
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (SETTLE < 1) begin : g_bad_settle
    $error("mul_share_ctrl: SETTLE must be >= 1");
  end

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               owner_q, owner_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [1:0]         gnt;
  logic               accept;
  logic               rsp_take;

  rr_arb2 u_arb (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_q),
    .grant_o      (gnt)
  );

  assign accept   = (state_q == IDLE) && (gnt != 2'b00);
  assign rsp_take = owner_q ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == IDLE) && gnt[0];
    req1_ready = (state_q == IDLE) && gnt[1];
    rsp0_valid = (state_q == RESP) && !owner_q;
    rsp1_valid = (state_q == RESP) &&  owner_q;
    rsp0_prod  = rsp0_valid ? prod_q : '0;
    rsp1_prod  = rsp1_valid ? prod_q : '0;
    busy       = (state_q != IDLE);
  end

  // Operand registers only move on accept so the multiplier input stays quiet when idle.
  always_comb begin
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    if (accept) begin
      a_d     = gnt[1] ? req1_a : req0_a;
      b_d     = gnt[1] ? req1_b : req0_b;
      owner_d = gnt[1];
      last_d  = gnt[1];
      cnt_d   = CW'(SETTLE - 1);
    end else if (state_q == WAIT) begin
      if (cnt_q == '0) prod_d = mul_prod;
      else             cnt_d  = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  assign mul_a = a_q;
  assign mul_b = b_q;

endmodule
